curve25519_stub: RTL

Parametrised, cycle-accurate stand-in for the Curve25519 scalar-multiplication engine. It is used in key-exchange integration and simulation until the real ladder core lands.
- Runs a start/busy/done handshake.
- Latches the scalar and point on an accepted start.
- Returns a deterministic result after a configurable latency.
- Sits between the key-exchange controller and the (future) arithmetic core, with an identical port contract.

---
 rtl/curve25519_pkg.sv | 18 +
 rtl/curve25519_stub.sv | 92 +++++++++
 2 files changed

// File: rtl/curve25519_pkg.sv
// Shared constants and field-element type for the Curve25519 engine and its stub.
package curve25519_pkg;

    localparam int CURVE_WIDTH      = 255;
    localparam int CURVE_BASE_POINT = 9;

    typedef logic [CURVE_WIDTH-1:0] fe_t;

    // Nibble patterns are built 256 bits wide and trimmed to the 255-bit field.
    localparam fe_t CURVE_OUT_BASE  = fe_t'({64{4'h3}});
    localparam fe_t CURVE_OUT_OTHER = fe_t'({64{4'h2}});

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } stub_state_t;

endpackage

// File: rtl/curve25519_stub.sv
// Cycle-accurate stand-in for the Curve25519 scalar-multiplication engine.
// Define CURVE25519_STUB_XOR_EN for a data-dependent result (n ^ q ^ OUT_OTHER).
module curve25519_stub
    import curve25519_pkg::*;
#(
    parameter int                WIDTH      = CURVE_WIDTH,
    parameter int                LATENCY    = 3,
    parameter logic [WIDTH-1:0]  BASE_POINT = WIDTH'(CURVE_BASE_POINT),
    parameter logic [WIDTH-1:0]  OUT_BASE   = WIDTH'(CURVE_OUT_BASE),
    parameter logic [WIDTH-1:0]  OUT_OTHER  = WIDTH'(CURVE_OUT_OTHER)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int             CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    stub_state_t      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] n_lat, n_lat_nx;
    logic [WIDTH-1:0] q_lat, q_lat_nx;
    logic [WIDTH-1:0] out_nx;
    logic             done_nx;
    logic [WIDTH-1:0] result;
    logic             unused_ok;

`ifdef CURVE25519_STUB_XOR_EN
    assign result    = n_lat ^ q_lat ^ OUT_OTHER;
    assign unused_ok = ^{BASE_POINT, OUT_BASE};
`else
    assign result    = (q_lat == BASE_POINT) ? OUT_BASE : OUT_OTHER;
    assign unused_ok = ^n_lat;
`endif

    assign busy = (state == ST_BUSY);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            n_lat <= '0;
            q_lat <= '0;
            out   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            n_lat <= n_lat_nx;
            q_lat <= q_lat_nx;
            out   <= out_nx;
            done  <= done_nx;
        end
    end

    // Counter is only decremented while nonzero; reaching zero in BUSY completes.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        n_lat_nx = n_lat;
        q_lat_nx = q_lat;
        out_nx   = out;
        done_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    n_lat_nx = n;
                    q_lat_nx = q;
                    cnt_nx   = CNT_LOAD;
                    state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    done_nx  = 1'b1;
                    out_nx   = result;
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
